// File: rtl/serial_frame_tx.sv
// serial_frame_tx: port-addressed serial frame transmitter.
// Optional even-parity bit after the payload: define PARITY_EN.
module serial_frame_tx #(
    parameter int   CNT_W    = 4,
    parameter int   DATA_W   = 2**CNT_W-1,
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clkEn,
    input  logic              start,
    input  logic [1:0]        port_num,
    input  logic [CNT_W-1:0]  data_num,
    input  logic [DATA_W-1:0] data_word,
    output logic              SerOut,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  remaining
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_PORT,
        S_NUM,
        S_DATA
`ifdef PARITY_EN
        , S_PAR
`endif
    } state_t;

    // State entered once the last payload (or count) bit has been sent.
`ifdef PARITY_EN
    localparam state_t TAIL = S_PAR;
`else
    localparam state_t TAIL = S_IDLE;
`endif

    localparam logic [CNT_W-1:0] NUM_LAST = CNT_W'(CNT_W-1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t              state_q, state_d;
    logic [1:0]          port_sr_q, port_sr_d;
    logic [CNT_W-1:0]    num_sr_q, num_sr_d;
    logic [CNT_W-1:0]    num_q, num_d;
    logic [DATA_W-1:0]   data_sr_q, data_sr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic                ser_q, ser_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
`ifdef PARITY_EN
    logic                par_q, par_d;
`endif

    // State and datapath registers; everything advances only on clkEn ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            port_sr_q <= '0;
            num_sr_q  <= '0;
            num_q     <= '0;
            data_sr_q <= '0;
            cnt_q     <= '0;
            rem_q     <= '0;
            ser_q     <= IDLE_LVL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef PARITY_EN
            par_q     <= 1'b0;
`endif
        end else if (clkEn) begin
            state_q   <= state_d;
            port_sr_q <= port_sr_d;
            num_sr_q  <= num_sr_d;
            num_q     <= num_d;
            data_sr_q <= data_sr_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            ser_q     <= ser_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    // Next-state: walk the frame fields, skipping DATA on a zero count.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_START;
            S_START: state_d = S_PORT;
            S_PORT:  if (cnt_q == ONE) state_d = S_NUM;
            S_NUM: begin
                if (cnt_q == NUM_LAST)
                    state_d = (num_q != '0) ? S_DATA : TAIL;
            end
            S_DATA:  if (rem_q == ONE) state_d = TAIL;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath: pick the bit for the next period and shift it out.
    always_comb begin
        port_sr_d = port_sr_q;
        num_sr_d  = num_sr_q;
        num_d     = num_q;
        data_sr_d = data_sr_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        ser_d     = ser_q;
        busy_d    = busy_q;
        done_d    = done_q;
`ifdef PARITY_EN
        par_d     = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                done_d = 1'b0;
                ser_d  = IDLE_LVL;
                if (start) begin
                    port_sr_d = port_num;
                    num_sr_d  = data_num;
                    num_d     = data_num;
                    data_sr_d = data_word;
                    ser_d     = ~IDLE_LVL;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
`ifdef PARITY_EN
                    par_d     = 1'b0;
`endif
                end
            end
            S_START: begin
                ser_d     = port_sr_q[1];
                port_sr_d = {port_sr_q[0], 1'b0};
            end
            S_PORT: begin
                cnt_d = cnt_q + ONE;
                if (state_d == S_NUM) begin
                    ser_d    = num_sr_q[CNT_W-1];
                    num_sr_d = num_sr_q << 1;
                    cnt_d    = '0;
                end else begin
                    ser_d     = port_sr_q[1];
                    port_sr_d = {port_sr_q[0], 1'b0};
                end
            end
            S_NUM: begin
                cnt_d = cnt_q + ONE;
                if (state_d == S_NUM) begin
                    ser_d    = num_sr_q[CNT_W-1];
                    num_sr_d = num_sr_q << 1;
                end else if (state_d == S_DATA) begin
                    ser_d     = data_sr_q[0];
                    data_sr_d = data_sr_q >> 1;
                    rem_d     = num_q;
                end
            end
            S_DATA: begin
                rem_d = rem_q - ONE;
                if (state_d == S_DATA) begin
                    ser_d     = data_sr_q[0];
                    data_sr_d = data_sr_q >> 1;
                end
            end
            default: ;
        endcase
`ifdef PARITY_EN
        // Parity covers every bit after the start bit.
        if (state_q inside {S_PORT, S_NUM, S_DATA})
            par_d = par_q ^ ser_q;
        if (state_d == S_PAR && state_q != S_PAR)
            ser_d = par_q ^ ser_q;
`endif
        if (state_d == S_IDLE && state_q != S_IDLE) begin
            ser_d  = IDLE_LVL;
            busy_d = 1'b0;
            done_d = 1'b1;
        end
    end

    assign SerOut    = ser_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign remaining = rem_q;

endmodule
